// File: rtl/branch_controller_pkg.sv
// Shared definitions for the branch controller: BHT counter type and
// encodings, controller state type and the B-type funct3 codes.
package branch_controller_pkg;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t SNT = 2'd0;  // strongly not-taken
  localparam bht_ctr_t WNT = 2'd1;  // weakly not-taken
  localparam bht_ctr_t WT  = 2'd2;  // weakly taken
  localparam bht_ctr_t ST  = 2'd3;  // strongly taken

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } bc_state_t;

  localparam logic [2:0] FN3_BEQ  = 3'b000;
  localparam logic [2:0] FN3_BNE  = 3'b001;
  localparam logic [2:0] FN3_BLT  = 3'b100;
  localparam logic [2:0] FN3_BGE  = 3'b101;
  localparam logic [2:0] FN3_BLTU = 3'b110;
  localparam logic [2:0] FN3_BGEU = 3'b111;

endpackage

// File: rtl/branch_controller_if.sv
// Fetch, EX-resolve, redirect and perf-counter signals of the branch controller.
//   master : pipeline side (drives fetch/EX info, consumes prediction/redirect)
//   slave  : branch_controller side
interface branch_controller_if #(
  parameter int PERF_W = 32
);
  logic              if_valid;
  logic              if_is_branch;
  logic [31:0]       if_pc;
  logic [31:0]       if_imm;
  logic              pred_taken;
  logic [31:0]       pred_target;
  logic              ex_valid;
  logic              ex_is_branch;
  logic              ex_is_jump;
  logic [31:0]       ex_pc;
  logic [31:0]       ex_target;
  logic              ex_taken;
  logic              ex_pred_taken;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              flush;
  logic              busy;
  logic [PERF_W-1:0] perf_branches;
  logic [PERF_W-1:0] perf_mispredicts;

  modport master (
    output if_valid, if_is_branch, if_pc, if_imm,
    output ex_valid, ex_is_branch, ex_is_jump, ex_pc, ex_target, ex_taken, ex_pred_taken,
    input  pred_taken, pred_target, redirect_valid, redirect_pc, flush, busy,
    input  perf_branches, perf_mispredicts
  );

  modport slave (
    input  if_valid, if_is_branch, if_pc, if_imm,
    input  ex_valid, ex_is_branch, ex_is_jump, ex_pc, ex_target, ex_taken, ex_pred_taken,
    output pred_taken, pred_target, redirect_valid, redirect_pc, flush, busy,
    output perf_branches, perf_mispredicts
  );

endinterface

// File: rtl/branch_controller_bht_2bit.sv
// Direct-mapped table of 2-bit saturating branch counters.
//   rd_idx_i / rd_ctr_o          : combinational read (pre-update value, no bypass)
//   wr_en_i / wr_idx_i / wr_taken_i : saturating increment (taken) or decrement
// All counters reset to weakly not-taken.
module bht_2bit
  import branch_controller_pkg::*;
#(
  parameter int ENTRIES = 64,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output bht_ctr_t         rd_ctr_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  bht_ctr_t ctr_q [ENTRIES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WNT;
    end else if (wr_en_i) begin
      if (wr_taken_i) begin
        if (ctr_q[wr_idx_i] != ST) ctr_q[wr_idx_i] <= ctr_q[wr_idx_i] + 2'd1;
      end else begin
        if (ctr_q[wr_idx_i] != SNT) ctr_q[wr_idx_i] <= ctr_q[wr_idx_i] - 2'd1;
      end
    end
  end

  assign rd_ctr_o = ctr_q[rd_idx_i];

endmodule

// File: rtl/branch_controller.sv
// Branch resolution sequencer: BHT prediction for fetch, mispredict/jump
// detection at EX, registered PC redirect + IF/ID flush, wrong-path squash
// window and branch/mispredict performance counters.
//   clk, rst : core clock, synchronous active-high reset
//   bus      : branch_controller_if slave (fetch, EX, redirect, perf)
//
// state  | meaning
// RUN    | accepting EX resolutions
// SQUASH | wrong-path window after a redirect; EX inputs ignored, busy = 1
module branch_controller
  import branch_controller_pkg::*;
#(
  parameter int BHT_ENTRIES   = 64,
  parameter int SHADOW_CYCLES = 2,
  parameter int PERF_W        = 32
) (
  input logic                clk,
  input logic                rst,
  branch_controller_if.slave bus
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam int CNT_W = $clog2(SHADOW_CYCLES + 1);

  bc_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [31:0]       redirect_pc_q, redirect_pc_d;
  logic [PERF_W-1:0] perf_br_q, perf_br_d;
  logic [PERF_W-1:0] perf_mp_q, perf_mp_d;

  logic     res, jmp_res, br_res, br_misp, redir;
  bht_ctr_t fetch_ctr;

  // A B-type flag together with a jump flag is treated as a jump.
  assign res     = (state_q == RUN) && bus.ex_valid && (bus.ex_is_branch || bus.ex_is_jump);
  assign jmp_res = res && bus.ex_is_jump;
  assign br_res  = res && bus.ex_is_branch && !bus.ex_is_jump;
  assign br_misp = br_res && (bus.ex_taken != bus.ex_pred_taken);
  assign redir   = jmp_res || br_misp;

  bht_2bit #(.ENTRIES(BHT_ENTRIES)) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rd_idx_i  (bus.if_pc[IDX_W+1:2]),
    .rd_ctr_o  (fetch_ctr),
    .wr_en_i   (br_res),
    .wr_idx_i  (bus.ex_pc[IDX_W+1:2]),
    .wr_taken_i(bus.ex_taken)
  );

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    redirect_valid_d = redir;
    redirect_pc_d    = redirect_pc_q;
    perf_br_d        = perf_br_q;
    perf_mp_d        = perf_mp_q;

    if (br_res)  perf_br_d = perf_br_q + PERF_W'(1);
    if (br_misp) perf_mp_d = perf_mp_q + PERF_W'(1);
    if (redir) begin
      redirect_pc_d = (jmp_res || bus.ex_taken) ? bus.ex_target : bus.ex_pc + 32'd4;
    end

    case (state_q)
      RUN: begin
        if (redir) begin
          state_d = SQUASH;
          cnt_d   = CNT_W'(SHADOW_CYCLES);
        end
      end
      SQUASH: begin
        if (cnt_q == CNT_W'(1)) state_d = RUN;
        cnt_d = cnt_q - CNT_W'(1);
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= RUN;
      cnt_q            <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      perf_br_q        <= '0;
      perf_mp_q        <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      perf_br_q        <= perf_br_d;
      perf_mp_q        <= perf_mp_d;
    end
  end

  assign bus.pred_taken       = bus.if_valid && bus.if_is_branch && (fetch_ctr >= WT);
  assign bus.pred_target      = bus.if_pc + bus.if_imm;
  assign bus.redirect_valid   = redirect_valid_q;
  assign bus.flush            = redirect_valid_q;
  assign bus.redirect_pc      = redirect_pc_q;
  assign bus.busy             = (state_q == SQUASH);
  assign bus.perf_branches    = perf_br_q;
  assign bus.perf_mispredicts = perf_mp_q;

endmodule

// File: tb/tb_branch_controller.sv
module tb_branch_controller;
  import branch_controller_pkg::*;

  localparam int N  = 64;
  localparam int SH = 2;
  localparam int PW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_controller_if #(.PERF_W(PW)) bus ();

  branch_controller #(.BHT_ENTRIES(N), .SHADOW_CYCLES(SH), .PERF_W(PW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int          m_bht [N];
  int          m_squash;   // remaining cycles in which EX results are ignored
  bit          m_rv;
  logic [31:0] m_rpc;
  logic [31:0] m_br, m_mp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic int ix(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) m_bht[i] = 1;
    m_squash = 0;
    m_rv     = 1'b0;
    m_rpc    = '0;
    m_br     = '0;
    m_mp     = '0;
  endtask

  task automatic ex_idle();
    bus.ex_valid = 0; bus.ex_is_branch = 0; bus.ex_is_jump = 0;
    bus.ex_pc = '0; bus.ex_target = '0; bus.ex_taken = 0; bus.ex_pred_taken = 0;
  endtask

  task automatic set_ex(input bit br, input bit jmp, input logic [31:0] pc,
                        input logic [31:0] tgt, input bit tk, input bit ptk);
    bus.ex_valid = 1; bus.ex_is_branch = br; bus.ex_is_jump = jmp;
    bus.ex_pc = pc; bus.ex_target = tgt; bus.ex_taken = tk; bus.ex_pred_taken = ptk;
  endtask

  task automatic set_if(input bit v, input bit b, input logic [31:0] pc, input logic [31:0] imm);
    bus.if_valid = v; bus.if_is_branch = b; bus.if_pc = pc; bus.if_imm = imm;
  endtask

  // One clock: check every output against the model mid-cycle, advance the
  // model from the inputs present this cycle, then step past the edge.
  task automatic cycle();
    bit acc, jmp, br, misp;
    int k;
    @(negedge clk);
    chk("pred_taken", 32'(bus.pred_taken),
        32'(bus.if_valid && bus.if_is_branch && m_bht[ix(bus.if_pc)] >= 2));
    chk("pred_target", bus.pred_target, bus.if_pc + bus.if_imm);
    chk("redirect_valid", 32'(bus.redirect_valid), 32'(m_rv));
    chk("flush", 32'(bus.flush), 32'(m_rv));
    chk("redirect_pc", bus.redirect_pc, m_rpc);
    chk("busy", 32'(bus.busy), 32'(m_squash > 0));
    chk("perf_branches", bus.perf_branches, m_br);
    chk("perf_mispredicts", bus.perf_mispredicts, m_mp);
    if (rst) begin
      m_reset();
    end else begin
      acc  = (m_squash == 0) && bus.ex_valid;
      jmp  = acc && bus.ex_is_jump;
      br   = acc && bus.ex_is_branch && !bus.ex_is_jump;
      misp = br && (bus.ex_taken != bus.ex_pred_taken);
      if (br) begin
        m_br++;
        k = ix(bus.ex_pc);
        if (bus.ex_taken) m_bht[k] = (m_bht[k] == 3) ? 3 : m_bht[k] + 1;
        else              m_bht[k] = (m_bht[k] == 0) ? 0 : m_bht[k] - 1;
      end
      if (misp) m_mp++;
      m_rv = jmp || misp;
      if (m_rv) begin
        m_rpc    = (jmp || bus.ex_taken) ? bus.ex_target : bus.ex_pc + 32'd4;
        m_squash = SH;
      end else if (m_squash > 0) begin
        m_squash--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ex_idle();
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1'b1;
    set_if(0, 0, '0, '0);
    ex_idle();
    @(posedge clk); #1;
    m_reset();
    cycle();
    rst = 1'b0;

    // fresh table: weakly not-taken
    set_if(1, 1, 32'h100, 32'h20);
    #1;
    chk("tp_reset_pred", 32'(bus.pred_taken), 32'd0);
    chk("tp_reset_target", bus.pred_target, 32'h120);
    cycle();

    // mispredicted taken branch at 0x100
    set_ex(1, 0, 32'h100, 32'h120, 1, 0);
    cycle();
    // now in first SQUASH cycle: same mispredicting branch must be ignored
    chk("tp_redirect", 32'(bus.redirect_valid), 32'd1);
    chk("tp_redirect_pc", bus.redirect_pc, 32'h120);
    set_ex(1, 0, 32'h100, 32'h300, 0, 1);
    cycle();
    cycle();
    ex_idle();
    chk("tp_squash_perf_br", bus.perf_branches, 32'd1);
    chk("tp_misp_count", bus.perf_mispredicts, 32'd1);
    chk("tp_pred_after", 32'(bus.pred_taken), 32'd1);
    idle(2);

    // saturate at 0x104, then one not-taken
    set_if(1, 1, 32'h104, 32'h8);
    for (int i = 0; i < 4; i++) begin
      set_ex(1, 0, 32'h104, 32'h10c, 1, 1);
      cycle();
    end
    set_ex(1, 0, 32'h104, 32'h10c, 0, 1);
    cycle();
    ex_idle();
    chk("tp_sat_pred", 32'(bus.pred_taken), 32'd1);
    chk("tp_sat_redirect_pc", bus.redirect_pc, 32'h108);
    idle(3);

    // not-taken at 0x200 predicted taken
    set_ex(1, 0, 32'h200, 32'h280, 0, 1);
    cycle();
    chk("tp_nt_redirect_pc", bus.redirect_pc, 32'h204);
    idle(3);

    // JALR: redirects, no BHT/perf change (model covers the latter)
    set_ex(0, 1, 32'h300, 32'h4000, 0, 0);
    cycle();
    chk("tp_jalr_pc", bus.redirect_pc, 32'h4000);
    idle(3);

    // same-cycle read/update of index 5
    set_if(1, 1, 32'h14, 32'h40);
    set_ex(1, 0, 32'h14, 32'h54, 1, 1);
    #1;
    chk("tp_same_idx_old", 32'(bus.pred_taken), 32'd0);
    cycle();
    ex_idle();
    chk("tp_same_idx_new", 32'(bus.pred_taken), 32'd1);
    idle(1);

    // reset in the first SQUASH cycle
    set_ex(1, 0, 32'h14, 32'h54, 0, 1);
    cycle();
    ex_idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("tp_rst_busy", 32'(bus.busy), 32'd0);
    chk("tp_rst_rv", 32'(bus.redirect_valid), 32'd0);
    set_if(1, 1, 32'h104, 32'h0);
    #1;
    chk("tp_rst_bht", 32'(bus.pred_taken), 32'd0);
    cycle();

    // randomized traffic over a small set of PCs so indices collide
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) < 2);
      set_if($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
             32'h1000 + ($urandom_range(0, 9) << 2) + ($urandom_range(0, 1) << 8), $urandom);
      if ($urandom_range(0, 3) != 0)
        set_ex($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
               32'h1000 + ($urandom_range(0, 9) << 2) + ($urandom_range(0, 1) << 8),
               {$urandom} & 32'hffff_fffc, $urandom_range(0, 1), $urandom_range(0, 1));
      else begin
        ex_idle();
        bus.ex_is_branch = 1'($urandom_range(0, 1));
        bus.ex_taken     = 1'($urandom_range(0, 1));
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_controller.md
Name: branch_controller

Overview:
- Sequences branch resolution for the pipelined RV32I core.
- Holds a direct-mapped 2-bit branch history table (BHT) and gives fetch a taken/not-taken prediction plus target.
- Takes the EX-stage BranchLogic `branch` outcome, detects mispredicts and jumps, and drives a registered PC redirect plus an IF/ID flush.
- Runs a squash window that ignores wrong-path EX results, and keeps branch/mispredict performance counters.

Parameters:
- BHT_ENTRIES, 64, number of 2-bit counters; power of two, at least 2.
- SHADOW_CYCLES, 2, cycles after a redirect during which EX resolutions are wrong-path and ignored; at least 1.
- PERF_W, 32, width of each performance counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- if_valid  in  1  fetch slot holds a valid instruction
- if_is_branch  in  1  predecode: instruction is B-type
- if_pc  in  32  fetch PC
- if_imm  in  32  predecoded, sign-extended B-type immediate
- pred_taken  out  1  prediction for the fetch slot
- pred_target  out  32  if_pc + if_imm
- ex_valid  in  1  EX slot holds a valid instruction
- ex_is_branch  in  1  EX instruction is B-type
- ex_is_jump  in  1  EX instruction is JAL or JALR
- ex_pc  in  32  EX instruction PC
- ex_target  in  32  computed branch/jump target
- ex_taken  in  1  BranchLogic outcome; ignored for jumps
- ex_pred_taken  in  1  prediction carried down the pipeline with the instruction
- redirect_valid  out  1  one-cycle pulse: fetch loads redirect_pc
- redirect_pc  out  32  corrected fetch address
- flush  out  1  squash IF/ID; equals redirect_valid
- busy  out  1  high while in SQUASH
- perf_branches  out  PERF_W  resolved conditional branches
- perf_mispredicts  out  PERF_W  mispredicted conditional branches

Behaviour:
- Reset values:
  - every BHT counter = 2'b01 (weakly not-taken)
  - redirect_valid = 0, flush = 0, busy = 0, redirect_pc = 0
  - perf counters = 0
  - state = RUN
- Index: idx = pc[$clog2(BHT_ENTRIES)+1:2] for both the fetch and the EX lookup.
- Prediction (combinational, zero latency):
  - pred_taken = if_valid & if_is_branch & bht[idx(if_pc)][1]
  - pred_target = if_pc + if_imm, mod 2^32; driven regardless of pred_taken.
- Resolve event (res) = state==RUN & ex_valid & (ex_is_branch | ex_is_jump).
  - If ex_is_branch and ex_is_jump are both high, treat the instruction as a jump.
- Mispredict (misp):
  - branch: res & ex_is_branch & (ex_taken != ex_pred_taken)
  - jump: every resolved jump redirects (there is no BTB).
- Redirect, registered with 1-cycle latency:
  - A redirect condition in cycle N drives redirect_valid = flush = 1 in cycle N+1, for exactly one cycle.
  - redirect_pc = ex_target if (jump | ex_taken), else ex_pc + 4 (mod 2^32).
- BHT update on res & ex_is_branch, at the clock edge ending cycle N:
  - taken increments the counter, saturating at 3; not taken decrements it, saturating at 0.
  - Jumps never update the BHT.
- Same-index read and write in one cycle: the fetch read returns the pre-update value (no bypass).
- Performance counters:
  - perf_branches increments on res & ex_is_branch.
  - perf_mispredicts increments on a branch mispredict.
  - Both wrap modulo 2^PERF_W.
- FSM:
  - RUN -> SQUASH on a redirect condition; load cnt = SHADOW_CYCLES.
  - SQUASH: busy = 1; EX inputs are ignored (no BHT or perf update, no redirect); cnt decrements each cycle.
  - SQUASH -> RUN when cnt == 1 at the clock edge; the first EX input accepted is the one in the cycle after that.
- A correctly predicted branch causes no redirect and no state change.
- Reset asserted mid-SQUASH or mid-redirect forces the reset values at the next edge; a pending redirect is dropped.
- ex_valid = 0 ignores all other ex_* inputs.

Decomposition:
- Shared core package holds:
  - bht_ctr_t (2-bit counter type)
  - counter constants: SNT = 0, WNT = 1, WT = 2, ST = 3
  - bc_state_t enum {RUN, SQUASH}
  - the `FN3_B*` codes, already in definitions
- One natural sub-module: bht_2bit, covering the counter array, combinational read port, saturating write port and reset-to-WNT.
- The FSM, redirect register and perf counters stay in branch_controller.

Test Plan:
- After reset, if_valid = 1, if_is_branch = 1, if_pc = 0x100, if_imm = 0x20 -> pred_taken = 0, pred_target = 0x120; perf counters = 0.
- Branch at ex_pc = 0x100, ex_taken = 1, ex_pred_taken = 0, ex_target = 0x120:
  - next cycle: redirect_valid = flush = 1, redirect_pc = 0x120
  - busy = 1 for 2 cycles
  - perf_mispredicts = 1, and bht[0] = 2, so a fetch of 0x100 now predicts taken.
- During SQUASH, a valid mispredicting branch at EX -> no redirect, perf_branches unchanged, bht unchanged.
- Four taken resolutions at 0x104 then one not-taken:
  - counter saturates at 3, then goes to 2
  - pred_taken stays 1.
- Not-taken branch at 0x200 with ex_pred_taken = 1 -> redirect_pc = 0x204.
- JALR, ex_target = 0x4000 -> redirect_pc = 0x4000, with no BHT or perf change.
- Same-cycle fetch and update of index 5: fetch sees the old counter, and the next cycle sees the new one.
- Reset asserted in the first SQUASH cycle -> busy = 0, redirect_valid = 0 next cycle, all counters back to 1.
